pixel_write_arbiter: RTL and testbench

Shares the graphic controller's single pixel-write port between `N_REQ` drawing clients, such as the touch-panel stroke writer and the UI overlay, and one screen-clear command. Each client gets a valid/ready handshake. Arbitration is round-robin, and each granted pixel is replayed onto the controller port as a fixed-length write slot. A pending clear pre-empts all clients and sweeps the full 320x240 frame.

---
 rtl/pixel_write_arbiter_if.sv | 30 +++
 rtl/pixel_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_write_arbiter_if.sv
// Bundle of the client request handshakes, clear command and controller pixel port.
// The arbiter connects through the slave modport; clients/controller use the master modport.
interface pixel_write_arbiter_if #(
    parameter int N_REQ = 2
);
    logic               gc_initialized;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*9-1:0] req_col;
    logic [N_REQ*8-1:0] req_row;
    logic [N_REQ-1:0]   req_color;
    logic               clear_req;
    logic               clear_color;
    logic [8:0]         pix_col;
    logic [7:0]         pix_row;
    logic               pix_color;
    logic               pix_write;
    logic               busy;
    logic               clear_done;

    modport slave (
        input  gc_initialized, req_valid, req_col, req_row, req_color, clear_req, clear_color,
        output req_ready, pix_col, pix_row, pix_color, pix_write, busy, clear_done
    );

    modport master (
        output gc_initialized, req_valid, req_col, req_row, req_color, clear_req, clear_color,
        input  req_ready, pix_col, pix_row, pix_color, pix_write, busy, clear_done
    );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing the graphic controller's pixel-write port between N_REQ clients
// and a full-frame clear sweep. Define PIXEL_WRITE_ARBITER_CLIP_EN to discard out-of-frame requests.
module pixel_write_arbiter #(
    parameter int N_REQ       = 2,
    parameter int COL_NUM     = 320,
    parameter int ROW_NUM     = 240,
    parameter int SLOT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_write_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int SW = $clog2(SLOT_CYCLES);

    typedef enum logic [1:0] {WAIT_INIT, IDLE, WRITE, CLEAR} state_t;

    state_t        state, state_next;
    logic [IW-1:0] last, grant_idx;
    logic [SW-1:0] slot_cnt;
    logic          clear_pend, clear_color_q;
    logic          found, accept, start_clear, in_range, slot_end, last_pixel;
    logic [8:0]    sel_col;
    logic [7:0]    sel_row;
    logic          sel_color;

    // Rotating priority: search starts at the client after the last one granted.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            int cand;
            cand = (int'(last) + k) % N_REQ;
            if (!found && bus.req_valid[IW'(cand)]) begin
                found     = 1'b1;
                grant_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        sel_col   = '0;
        sel_row   = '0;
        sel_color = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == grant_idx) begin
                sel_col   = bus.req_col[i*9 +: 9];
                sel_row   = bus.req_row[i*8 +: 8];
                sel_color = bus.req_color[i];
            end
        end
    end

`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
    assign in_range = (int'(sel_col) < COL_NUM) && (int'(sel_row) < ROW_NUM);
`else
    assign in_range = 1'b1;
`endif

    assign slot_end   = (slot_cnt == SW'(SLOT_CYCLES - 1));
    assign last_pixel = (bus.pix_col == 9'(COL_NUM - 1)) && (bus.pix_row == 8'(ROW_NUM - 1));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        accept        = 1'b0;
        start_clear   = 1'b0;
        case (state)
            WAIT_INIT: if (bus.gc_initialized) state_next = IDLE;
            IDLE: begin
                if (clear_pend) begin
                    start_clear = 1'b1;
                    state_next  = CLEAR;
                end else if (found) begin
                    bus.req_ready[grant_idx] = 1'b1;
                    accept                   = 1'b1;
                    if (in_range) state_next = WRITE;
                end
            end
            WRITE: if (slot_end) state_next = IDLE;
            CLEAR: if (slot_end && last_pixel) state_next = IDLE;
            default: state_next = WAIT_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_INIT;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last           <= IW'(N_REQ - 1);
            slot_cnt       <= '0;
            clear_pend     <= 1'b0;
            clear_color_q  <= 1'b0;
            bus.pix_col    <= '0;
            bus.pix_row    <= '0;
            bus.pix_color  <= 1'b0;
            bus.pix_write  <= 1'b0;
            bus.busy       <= 1'b1;
            bus.clear_done <= 1'b0;
        end else begin
            bus.pix_write  <= 1'b0;
            bus.clear_done <= 1'b0;
            bus.busy       <= (state_next != IDLE);

            if (accept) last <= grant_idx;

            if (accept && in_range) begin
                bus.pix_col   <= sel_col;
                bus.pix_row   <= sel_row;
                bus.pix_color <= sel_color;
                bus.pix_write <= 1'b1;
                slot_cnt      <= '0;
            end

            if (start_clear) begin
                bus.pix_col   <= '0;
                bus.pix_row   <= '0;
                bus.pix_color <= clear_color_q;
                bus.pix_write <= 1'b1;
                slot_cnt      <= '0;
                clear_pend    <= 1'b0;
            end

            if (state == WRITE) slot_cnt <= slot_cnt + SW'(1);

            if (state == CLEAR) begin
                if (!slot_end) begin
                    slot_cnt <= slot_cnt + SW'(1);
                end else if (last_pixel) begin
                    bus.clear_done <= 1'b1;
                end else begin
                    // Row-major sweep: wrap the column and step the row at the frame edge.
                    if (bus.pix_col == 9'(COL_NUM - 1)) begin
                        bus.pix_col <= '0;
                        bus.pix_row <= bus.pix_row + 8'd1;
                    end else begin
                        bus.pix_col <= bus.pix_col + 9'd1;
                    end
                    bus.pix_write <= 1'b1;
                    slot_cnt      <= '0;
                end
            end

            // A newly arriving clear outranks the entry-clear above; ignored while sweeping.
            if (bus.clear_req && state != CLEAR) begin
                clear_pend    <= 1'b1;
                clear_color_q <= bus.clear_color;
            end
        end
    end
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter on a reduced 5x3 frame so a whole sweep stays short.
// Expectations follow PIXEL_WRITE_ARBITER_CLIP_EN when the bench is built with it.
module tb_pixel_write_arbiter;
    localparam int N_REQ = 2;
    localparam int COLS  = 5;
    localparam int ROWS  = 3;
    localparam int SLOT  = 3;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    pixel_write_arbiter_if #(.N_REQ(N_REQ)) bus ();

    pixel_write_arbiter #(
        .N_REQ(N_REQ), .COL_NUM(COLS), .ROW_NUM(ROWS), .SLOT_CYCLES(SLOT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, p, sweep_len, early_done, done_at_end, order_bad, color_bad, blocked_bad, last_r, last_c;
        int found;

        reset              = 1'b1;
        bus.gc_initialized = 1'b0;
        bus.req_valid      = '0;
        bus.req_col        = '0;
        bus.req_row        = '0;
        bus.req_color      = '0;
        bus.clear_req      = 1'b0;
        bus.clear_color    = 1'b0;
        step();
        step();

        // Reset state.
        check("rst_busy", bus.busy, 1);
        check("rst_ready", bus.req_ready, 0);
        check("rst_write", bus.pix_write, 0);
        check("rst_col", bus.pix_col, 0);
        check("rst_done", bus.clear_done, 0);

        // Wait for the controller with a client already asking.
        reset         = 1'b0;
        bus.req_valid = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step();
            check("wait_busy", bus.busy, 1);
            check("wait_ready", bus.req_ready, 0);
        end
        bus.req_valid      = '0;
        bus.gc_initialized = 1'b1;
        step();
        check("init_idle", bus.busy, 0);

        // Single client write (5,7,1).
        bus.req_col   = {9'd10, 9'd5};
        bus.req_row   = {8'd20, 8'd7};
        bus.req_color = 2'b01;
        bus.req_valid = 2'b01;
        #1;
        check("w_ready", bus.req_ready, 2'b01);
        step();
        bus.req_valid = '0;
        check("w_write1", bus.pix_write, 1);
        check("w_col", bus.pix_col, 5);
        check("w_row", bus.pix_row, 7);
        check("w_color", bus.pix_color, 1);
        step();
        check("w_write2", bus.pix_write, 0);
        check("w_hold_col", bus.pix_col, 5);
        step();
        check("w_hold_row", bus.pix_row, 7);
        check("w_busy3", bus.busy, 1);
        step();
        check("w_idle", bus.busy, 0);

        // Both clients continuously valid: client 1 first (client 0 went last), then alternate.
        bus.req_valid = 2'b11;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            check("rr_ready", bus.req_ready, (i % 4 == 0) ? (((i / 4) % 2 == 0) ? 2 : 1) : 0);
            check("rr_write", bus.pix_write, (i % 4 == 1) ? 1 : 0);
            if (i % 4 == 1) check("rr_col", bus.pix_col, ((i / 4) % 2 == 0) ? 10 : 5);
        end
        bus.req_valid = '0;
        step();

        // Clear arrives during a client slot; client 1 waits behind the sweep.
        bus.req_col   = {9'd9, 9'd1};
        bus.req_row   = {8'd1, 8'd2};
        bus.req_color = 2'b10;
        bus.req_valid = 2'b01;
        #1;
        check("c_client_ready", bus.req_ready, 2'b01);
        step();
        bus.req_valid   = 2'b10;
        bus.clear_req   = 1'b1;
        bus.clear_color = 1'b1;
        step();
        bus.clear_req   = 1'b0;
        bus.clear_color = 1'b0;
        step();
        step();
        check("c_slot_kept", bus.pix_col, 1);
        check("c_pend_block", bus.req_ready, 0);
        step();
        sweep_len = -1; early_done = 0; done_at_end = 0; order_bad = 0;
        color_bad = 0; blocked_bad = 0; p = 0; last_r = -1; last_c = -1;
        for (k = 0; k < 200; k++) begin
            if (k > 0) step();
            if (!bus.busy) begin
                sweep_len   = k;
                done_at_end = bus.clear_done;
                break;
            end
            if (bus.clear_done) early_done++;
            if (bus.req_ready != 0) blocked_bad++;
            if (bus.pix_write) begin
                if (k != p * SLOT || bus.pix_row != 8'(p / COLS) || bus.pix_col != 9'(p % COLS))
                    order_bad++;
                if (bus.pix_color != 1'b1) color_bad++;
                last_r = bus.pix_row;
                last_c = bus.pix_col;
                p++;
            end
        end
        check("c_sweep_len", sweep_len, COLS * ROWS * SLOT);
        check("c_pulses", p, COLS * ROWS);
        check("c_order", order_bad, 0);
        check("c_color", color_bad, 0);
        check("c_blocked", blocked_bad, 0);
        check("c_last_row", last_r, ROWS - 1);
        check("c_last_col", last_c, COLS - 1);
        check("c_early_done", early_done, 0);
        check("c_done", done_at_end, 1);
        check("c_after_ready", bus.req_ready, 2'b10);
        step();
        bus.req_valid = '0;
        check("c_done_once", bus.clear_done, 0);
        check("c_after_col", bus.pix_col, 9);
        step();
        step();
        step();

        // Column 320 from client 0: driven unchecked unless clipping is built in.
        bus.req_col   = {9'd0, 9'd320};
        bus.req_row   = '0;
        bus.req_color = 2'b01;
        bus.req_valid = 2'b01;
        #1;
        check("clip_ready", bus.req_ready, 2'b01);
        step();
        bus.req_valid = '0;
`ifdef PIXEL_WRITE_ARBITER_CLIP_EN
        check("clip_write", bus.pix_write, 0);
        check("clip_busy", bus.busy, 0);
`else
        check("clip_write", bus.pix_write, 1);
        check("clip_col", bus.pix_col, 320);
`endif
        step();
        step();
        step();

        // Client and clear together: client first, then the sweep; reset it at pixel (1,2).
        bus.req_col     = {9'd0, 9'd3};
        bus.req_row     = {8'd0, 8'd1};
        bus.req_valid   = 2'b01;
        bus.clear_req   = 1'b1;
        bus.clear_color = 1'b1;
        #1;
        check("r_ready", bus.req_ready, 2'b01);
        step();
        bus.req_valid = '0;
        bus.clear_req = 1'b0;
        check("r_client_first", bus.pix_col, 3);
        step();
        step();
        step();
        step();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.pix_write && bus.pix_row == 8'd1 && bus.pix_col == 9'd2) begin
                found = 1;
                break;
            end
            step();
        end
        check("r_reach_pixel", found, 1);
        reset              = 1'b1;
        bus.gc_initialized = 1'b0;
        step();
        check("r_busy", bus.busy, 1);
        check("r_write", bus.pix_write, 0);
        check("r_col", bus.pix_col, 0);
        check("r_row", bus.pix_row, 0);
        check("r_color", bus.pix_color, 0);
        check("r_done", bus.clear_done, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("r_wait_busy", bus.busy, 1);
            check("r_no_done", bus.clear_done, 0);
        end
        bus.gc_initialized = 1'b1;
        step();
        check("r_idle", bus.busy, 0);
        step();
        check("r_no_clear", bus.busy, 0);
        check("r_no_write", bus.pix_write, 0);
        bus.req_valid = 2'b11;
        #1;
        check("r_client0_first", bus.req_ready, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
